// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings and widths.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);
  localparam int LAT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read, no reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      else      r_rdata      <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory target: one word access at a time with a fixed
// wait latency, a one-cycle done pulse and a stall for the pipeline.
//
// state | meaning
// IDLE  | waiting for req; latches request and checks alignment/range
// WAIT  | latency countdown; access happens on the edge leaving WAIT
// RESP  | done=1 for one cycle with err/rdata valid
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

  state_t             r_state;
  logic [LAT_W-1:0]   r_count;
  logic               r_we;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic               r_done;
  logic               r_err;
  logic               r_rd_ok;

  logic               w_addr_err;
  logic               w_arr_en;
  logic [31:0]        w_arr_rdata;

  assign w_addr_err = (adr[BYTE_OFF_W-1:0] != '0) || (adr[31:2] >= DEPTH_L);
  assign w_arr_en   = (r_state == ST_WAIT) && (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rd_ok <= 1'b0;
          if (req) begin
            r_we    <= we;
            r_idx   <= adr[IDX_W+1:2];
            r_wdata <= wdata;
            if (w_addr_err) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_count <= LAT_W'(LATENCY);
            end
          end
        end
        ST_WAIT: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_state <= ST_RESP;
            r_done  <= 1'b1;
            r_rd_ok <= ~r_we;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rd_ok <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rd_ok <= 1'b0;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_arr_en),
    .i_we    (r_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  // The array holds its last read value; only expose it during a load response.
  assign rdata = r_rd_ok ? w_arr_rdata : 32'h0;
  assign done  = r_done;
  assign err   = r_err;
  assign stall = req & ~r_done;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU's MEM stage. It is the target end of the load/store request interface the pipeline drives.
- Accepts one word request at a time (read or write), models a configurable access latency, and returns read data with a one-cycle done pulse.
- Provides a stall signal so the CPU can freeze the pipeline while an access is outstanding.
- Replaces the zero-latency combinational data memory in the CPU datapath.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; a power of two, at least 4.
- LATENCY, 2, extra wait cycles per access; range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  access request from MEM stage; held high until done.
- we  input  1  1 = store (sw), 0 = load (lw); sampled with req.
- adr  input  32  byte address (ALU result); sampled with req.
- wdata  input  32  store data (busB); sampled with req.
- rdata  output  32  load data; valid only while done=1, else 0.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = misaligned or out-of-range access.
- stall  output  1  combinational: req & ~done; freezes pipeline registers.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, done=0, err=0, rdata=0.
  - Latched request registers cleared.
  - Storage contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at a rising edge, latch we/adr/wdata.
  - Error check: adr[1:0]!=0, or word index adr[31:2] >= DEPTH_WORDS.
  - Error: go to RESP with err=1, rdata=0. No storage write occurs.
  - No error: go to WAIT with count=LATENCY.
- WAIT:
  - If count!=0, count decrements each cycle.
  - If count==0, go to RESP at that edge and perform the access on the same edge:
    - write: storage[idx] <= wdata_latched;
    - read: rdata <= storage[idx].
  - adr/we/wdata changes during WAIT are ignored; the latched copy is used.
- RESP:
  - done=1 for exactly one cycle; err and rdata are valid.
  - Next edge: back to IDLE. done, err and rdata return to 0.
  - req is not sampled in RESP. A req still high in the following IDLE cycle is a new request, so the CPU must drop or advance req in the cycle done is seen.
- Latency, with the first cycle of req=1 in IDLE as cycle 0:
  - valid access: done high in cycle LATENCY+2;
  - error access: done high in cycle 1.
- Throughput: one access per LATENCY+3 cycles.
- req deasserted during WAIT (protocol violation): the access still completes and done still pulses; the bench flags this as a violation.
- Reset during WAIT: the access is aborted and no write is committed. Reset during RESP: the write has already been committed.
- Read-after-write to the same word returns the new data; there is no bypass needed because accesses are serialized.
- stall is combinational from req and the registered done, so there is no combinational loop back to req.

Decomposition:
- Shared package dmem_pkg:
  - state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - WORD_BYTES=4;
  - LAT_W=4 (counter width).
- Sub-module dmem_array: DEPTH_WORDS x 32 single-port storage.
  - Synchronous write and registered read, both on one clk edge, enabled by the FSM.
  - No reset.
- All FSM, counter, error check and output registers live in dmem_responder.

Test Plan:
- LATENCY=2, store then load:
  - req=1, we=1, adr=0x00000010, wdata=0xDEADBEEF -> done in cycle 4 with err=0 and stall=1 in cycles 0-3.
  - Then load from 0x10 -> rdata=0xDEADBEEF in its done cycle.
- Misaligned and out-of-range, DEPTH=256:
  - load adr=0x00000013 -> done in cycle 1 with err=1, rdata=0.
  - store adr=0x00000400 -> err=1, and a later load from 0x0 is unchanged.
- LATENCY=0 -> done in cycle 2. Back-to-back loads from 0x4 and 0x8 complete 3 cycles apart, with done a one-cycle pulse each time.
- Input hold check: change adr from 0x10 to 0x20 and wdata during WAIT -> the write lands at 0x10 with the original data, and 0x20 is untouched.
- Reset mid-operation: store 0x12345678 to 0x8, pulse rst_n=0 in cycle 2 -> done, err and rdata all 0 immediately (async). A subsequent load of 0x8 returns the prior value.
